// File: rtl/debounce_pkg.sv
`default_nettype none
// ============================================================================
// Module      : debounce_pkg
// Description : Shared constants and helper functions for the multi-channel
//               debouncer: stable-window length computation and a $clog2
//               wrapper that never returns a zero width.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package debounce_pkg;

    // Number of clk cycles in one stable window.
    function automatic int counter_value(input int sys_freq,
                                         input int time_base,
                                         input int time_lapes);
        return (sys_freq / time_base) * time_lapes;
    endfunction

    // Bit width able to hold values 0..value-1, never less than one bit so
    // degenerate parameter choices still produce legal vector declarations.
    function automatic int clog2_min1(input int value);
        return (value <= 2) ? 1 : $clog2(value);
    endfunction

endpackage : debounce_pkg
`default_nettype wire

// File: rtl/debouncer_multi_if.sv
`default_nettype none
// ============================================================================
// Module      : debouncer_multi_if
// Description : Signal bundle between raw board inputs and the debouncer.
//               master : side that drives the raw inputs and consumes the
//                        debounced levels and ticks (board / control logic)
//               slave  : the debouncer itself
// Ports       : sw   - raw asynchronous inputs, CHANNELS bits
//               deb  - debounced levels, CHANNELS bits
//               rise - one-cycle tick when deb[i] goes 0->1
//               fall - one-cycle tick when deb[i] goes 1->0
//               hold - one-cycle tick when a long press is detected
// Revision    : 1.0 - initial release
// ============================================================================
interface debouncer_multi_if #(
    parameter int CHANNELS = 4
);
    logic [CHANNELS-1:0] sw;
    logic [CHANNELS-1:0] deb;
    logic [CHANNELS-1:0] rise;
    logic [CHANNELS-1:0] fall;
    logic [CHANNELS-1:0] hold;

    modport master (
        output sw,
        input  deb,
        input  rise,
        input  fall,
        input  hold
    );

    modport slave (
        input  sw,
        output deb,
        output rise,
        output fall,
        output hold
    );
endinterface : debouncer_multi_if
`default_nettype wire

// File: rtl/debounce_channel.sv
`default_nettype none
// ============================================================================
// Module      : debounce_channel
// Description : One debouncer lane: SYNC_STAGES-deep synchroniser, stable
//               window counter, debounced level with rise/fall ticks and an
//               optional long-press (hold) tick.
// Ports       : clk    - system clock, rising edge
//               rst    - asynchronous active-high reset
//               i_sw   - raw asynchronous input
//               o_deb  - debounced level
//               o_rise - one-cycle tick on the first cycle o_deb reads 1
//               o_fall - one-cycle tick on the first cycle o_deb reads 0
//               o_hold - one-cycle tick after HOLD_PERIODS stable-high windows
// Revision    : 1.0 - initial release
// ============================================================================
module debounce_channel
    import debounce_pkg::*;
#(
    parameter int   COUNTER      = 4,
    parameter int   SYNC_STAGES  = 2,
    parameter int   HOLD_PERIODS = 100,
    parameter logic RESET_LEVEL  = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic i_sw,
    output logic o_deb,
    output logic o_rise,
    output logic o_fall,
    output logic o_hold
);

    localparam int            CW         = clog2_min1(COUNTER);
    localparam logic [CW-1:0] C_CNT_LAST = CW'(COUNTER - 1);

    generate
        if (COUNTER < 2) begin : g_bad_counter
            $error("debounce_channel: stable window must be at least 2 cycles");
        end
        if (SYNC_STAGES < 2) begin : g_bad_sync
            $error("debounce_channel: SYNC_STAGES must be at least 2");
        end
    endgenerate

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_last;
    logic [CW-1:0]          r_cnt;
    logic                   r_deb;
    logic                   r_rise;
    logic                   r_fall;

    logic w_s;
    logic w_chg;
    logic w_term;
    logic w_upd;

    assign w_s    = r_sync[SYNC_STAGES-1];
    assign w_chg  = w_s ^ r_last;
    // Terminal event: window completed with no change seen on this edge.
    assign w_term = !w_chg && (r_cnt == C_CNT_LAST);
    // Terminal event that actually moves the debounced level.
    assign w_upd  = w_term && (r_last != r_deb);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync <= {SYNC_STAGES{RESET_LEVEL}};
            r_last <= RESET_LEVEL;
            r_cnt  <= '0;
            r_deb  <= RESET_LEVEL;
            r_rise <= 1'b0;
            r_fall <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_sw};
            r_last <= w_s;
            r_rise <= 1'b0;
            r_fall <= 1'b0;
            if (w_chg) begin
                r_cnt <= '0;
            end else if (r_cnt == C_CNT_LAST) begin
                // The counter wraps even when deb is already correct so the
                // hold logic sees a terminal event every COUNTER cycles.
                r_cnt <= '0;
                if (w_upd) begin
                    r_deb  <= r_last;
                    r_rise <= r_last;
                    r_fall <= !r_last;
                end
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign o_deb  = r_deb;
    assign o_rise = r_rise;
    assign o_fall = r_fall;

    generate
        if (HOLD_PERIODS > 0) begin : g_hold
            localparam int            HW          = clog2_min1(HOLD_PERIODS + 1);
            localparam logic [HW-1:0] C_HOLD_MAX  = HW'(HOLD_PERIODS);
            localparam logic [HW-1:0] C_HOLD_LAST = HW'(HOLD_PERIODS - 1);

            logic [HW-1:0] r_hold_cnt;
            logic          r_hold;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_hold_cnt <= '0;
                    r_hold     <= 1'b0;
                end else begin
                    r_hold <= 1'b0;
                    if (w_upd || !r_deb) begin
                        // New press starts counting from the rise edge; a
                        // fall (or any low time) cancels a pending hold.
                        r_hold_cnt <= '0;
                    end else if (w_term && (r_hold_cnt != C_HOLD_MAX)) begin
                        // Saturating at the maximum limits hold to one tick
                        // per press.
                        r_hold_cnt <= r_hold_cnt + 1'b1;
                        if (r_hold_cnt == C_HOLD_LAST) begin
                            r_hold <= 1'b1;
                        end
                    end
                end
            end

            assign o_hold = r_hold;
        end else begin : g_no_hold
            assign o_hold = 1'b0;
        end
    endgenerate

endmodule : debounce_channel
`default_nettype wire

// File: rtl/debouncer_multi.sv
`default_nettype none
// ============================================================================
// Module      : debouncer_multi
// Description : CHANNELS independent switch debouncers. Each lane is a
//               debounce_channel; this level only splits and merges vectors.
// Ports       : clk - system clock, rising edge
//               rst - asynchronous active-high reset
//               bus - debouncer_multi_if.slave (sw in; deb/rise/fall/hold out)
// Revision    : 1.0 - initial release
// ============================================================================
module debouncer_multi
    import debounce_pkg::*;
#(
    parameter int                  CHANNELS     = 4,
    parameter int                  SYS_FREQ     = 100_000_000,
    parameter int                  TIME_LAPES   = 10,
    parameter int                  TIME_BASE    = 1000,
    parameter int                  SYNC_STAGES  = 2,
    parameter logic [CHANNELS-1:0] RESET_LEVEL  = '0,
    parameter int                  HOLD_PERIODS = 100
) (
    input  logic             clk,
    input  logic             rst,
    debouncer_multi_if.slave bus
);

    localparam int C_COUNTER = counter_value(SYS_FREQ, TIME_BASE, TIME_LAPES);

    generate
        if (CHANNELS < 1) begin : g_bad_channels
            $error("debouncer_multi: CHANNELS must be at least 1");
        end
    endgenerate

    logic [CHANNELS-1:0] w_deb;
    logic [CHANNELS-1:0] w_rise;
    logic [CHANNELS-1:0] w_fall;
    logic [CHANNELS-1:0] w_hold;

    genvar i;
    generate
        for (i = 0; i < CHANNELS; i++) begin : g_ch
            debounce_channel #(
                .COUNTER     (C_COUNTER),
                .SYNC_STAGES (SYNC_STAGES),
                .HOLD_PERIODS(HOLD_PERIODS),
                .RESET_LEVEL (RESET_LEVEL[i])
            ) u_channel (
                .clk   (clk),
                .rst   (rst),
                .i_sw  (bus.sw[i]),
                .o_deb (w_deb[i]),
                .o_rise(w_rise[i]),
                .o_fall(w_fall[i]),
                .o_hold(w_hold[i])
            );
        end
    endgenerate

    assign bus.deb  = w_deb;
    assign bus.rise = w_rise;
    assign bus.fall = w_fall;
    assign bus.hold = w_hold;

endmodule : debouncer_multi
`default_nettype wire

// File: tb/tb_debouncer_multi.sv
`default_nettype none
// ============================================================================
// Module      : tb_debouncer_multi
// Description : Directed self-checking bench for debouncer_multi with a
//               4-cycle window (COUNTER=4), 2 sync stages, HOLD_PERIODS=3.
//               Inputs change 1 time unit after a rising edge; the next
//               rising edge is "edge 1" of a scenario, and each tick() call
//               advances one edge and samples 1 time unit later. A clean step
//               therefore appears on deb at tick 7 (SYNC_STAGES+COUNTER+1),
//               and the hold tick 12 ticks after rise.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_debouncer_multi;

    localparam int C_LAT  = 7;   // step-to-deb latency in ticks
    localparam int C_HOLD = 12;  // HOLD_PERIODS * COUNTER

    logic clk;
    logic rst;
    int   n_run;
    int   n_fail;

    debouncer_multi_if #(.CHANNELS(4)) bus ();

    debouncer_multi #(
        .CHANNELS    (4),
        .SYS_FREQ    (1000),
        .TIME_LAPES  (4),
        .TIME_BASE   (1000),
        .SYNC_STAGES (2),
        .RESET_LEVEL (4'b0000),
        .HOLD_PERIODS(3)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst    = 1'b1;
        bus.sw = 4'b0000;
        tick();
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        logic [15:0] outs;
        rst    = 1'b1;
        bus.sw = 4'b0000;
        repeat (3) tick();
        outs = {bus.deb, bus.rise, bus.fall, bus.hold};
        n_run++;
        if (outs !== 16'h0000) begin
            n_fail++;
            $display("FAIL reset_held: outputs=%h expected 0000", outs);
        end
        rst = 1'b0;
        for (int t = 1; t <= 20; t++) begin
            tick();
            outs = {bus.deb, bus.rise, bus.fall, bus.hold};
            n_run++;
            if (outs !== 16'h0000) begin
                n_fail++;
                $display("FAIL reset_release t=%0d: outputs=%h expected 0000", t, outs);
            end
        end
    endtask

    task automatic test_clean_step();
        int first_deb = 0;
        int rise_t    = 0;
        int n_rise    = 0;
        int other_bad = 0;
        apply_reset();
        bus.sw = 4'b0001;
        for (int t = 1; t <= 12; t++) begin
            tick();
            if (bus.deb[0] === 1'b1 && first_deb == 0) first_deb = t;
            if (bus.rise[0] === 1'b1) begin
                n_rise++;
                rise_t = t;
            end
            if (bus.deb[3:1] !== 3'b000 || bus.rise[3:1] !== 3'b000 ||
                bus.fall !== 4'b0000 || bus.hold !== 4'b0000) other_bad++;
        end
        n_run++;
        if (first_deb != C_LAT) begin
            n_fail++;
            $display("FAIL step_deb_latency: got tick %0d expected %0d", first_deb, C_LAT);
        end
        n_run++;
        if (rise_t != C_LAT) begin
            n_fail++;
            $display("FAIL step_rise_tick: got tick %0d expected %0d", rise_t, C_LAT);
        end
        n_run++;
        if (n_rise != 1) begin
            n_fail++;
            $display("FAIL step_rise_count: got %0d expected 1", n_rise);
        end
        n_run++;
        if (other_bad != 0) begin
            n_fail++;
            $display("FAIL step_other_channels: %0d bad cycles expected 0", other_bad);
        end
    endtask

    task automatic test_bounce();
        int pat [4] = '{1, 0, 1, 0};
        int first_deb = 0;
        int n_rise    = 0;
        int n_fall    = 0;
        apply_reset();
        for (int k = 0; k < 4; k++) begin
            bus.sw[1] = pat[k][0];
            repeat (2) begin
                tick();
                if (bus.rise[1] === 1'b1) n_rise++;
                if (bus.fall[1] === 1'b1) n_fall++;
                if (bus.deb[1] === 1'b1 && first_deb == 0) first_deb = -1;
            end
        end
        bus.sw[1] = 1'b1;
        for (int t = 1; t <= 16; t++) begin
            tick();
            if (bus.rise[1] === 1'b1) n_rise++;
            if (bus.fall[1] === 1'b1) n_fall++;
            if (bus.deb[1] === 1'b1 && first_deb == 0) first_deb = t;
        end
        n_run++;
        if (first_deb != C_LAT) begin
            n_fail++;
            $display("FAIL bounce_deb_latency: got tick %0d expected %0d", first_deb, C_LAT);
        end
        n_run++;
        if (n_rise != 1) begin
            n_fail++;
            $display("FAIL bounce_rise_count: got %0d expected 1", n_rise);
        end
        n_run++;
        if (n_fall != 0) begin
            n_fail++;
            $display("FAIL bounce_fall_count: got %0d expected 0", n_fall);
        end
    endtask

    task automatic test_glitch();
        int seen_deb = 0;
        int n_ticks  = 0;
        apply_reset();
        bus.sw[2] = 1'b1;
        for (int t = 1; t <= 18; t++) begin
            tick();
            if (t == 3) bus.sw[2] = 1'b0;
            if (bus.deb[2] !== 1'b0) seen_deb++;
            if (bus.rise[2] !== 1'b0 || bus.fall[2] !== 1'b0 || bus.hold[2] !== 1'b0) n_ticks++;
        end
        n_run++;
        if (seen_deb != 0) begin
            n_fail++;
            $display("FAIL glitch_deb: high for %0d cycles expected 0", seen_deb);
        end
        n_run++;
        if (n_ticks != 0) begin
            n_fail++;
            $display("FAIL glitch_ticks: got %0d ticks expected 0", n_ticks);
        end
    endtask

    task automatic test_long_press();
        int rise_t = 0;
        int hold_t = 0;
        int n_hold = 0;
        int fall_t = 0;
        int n_fall = 0;
        apply_reset();
        // First press held 30 ticks.
        bus.sw[3] = 1'b1;
        for (int t = 1; t <= 30; t++) begin
            tick();
            if (bus.rise[3] === 1'b1 && rise_t == 0) rise_t = t;
            if (bus.hold[3] === 1'b1) begin
                n_hold++;
                hold_t = t;
            end
        end
        bus.sw[3] = 1'b0;
        for (int t = 1; t <= 12; t++) begin
            tick();
            if (bus.fall[3] === 1'b1) begin
                n_fall++;
                fall_t = t;
            end
            if (bus.hold[3] === 1'b1) n_hold++;
        end
        n_run++;
        if (rise_t != C_LAT) begin
            n_fail++;
            $display("FAIL press_rise_tick: got %0d expected %0d", rise_t, C_LAT);
        end
        n_run++;
        if (hold_t != C_LAT + C_HOLD) begin
            n_fail++;
            $display("FAIL press_hold_tick: got %0d expected %0d", hold_t, C_LAT + C_HOLD);
        end
        n_run++;
        if (n_hold != 1) begin
            n_fail++;
            $display("FAIL press_hold_count: got %0d expected 1", n_hold);
        end
        n_run++;
        if (fall_t != C_LAT || n_fall != 1) begin
            n_fail++;
            $display("FAIL press_fall: tick %0d count %0d expected tick %0d count 1",
                     fall_t, n_fall, C_LAT);
        end
        // Second press released after 10 ticks: deb falls at tick 17,
        // before the hold point at tick 19, so no hold.
        rise_t = 0;
        fall_t = 0;
        n_hold = 0;
        bus.sw[3] = 1'b1;
        for (int t = 1; t <= 35; t++) begin
            tick();
            if (t == 10) bus.sw[3] = 1'b0;
            if (bus.rise[3] === 1'b1 && rise_t == 0) rise_t = t;
            if (bus.fall[3] === 1'b1 && fall_t == 0) fall_t = t;
            if (bus.hold[3] === 1'b1) n_hold++;
        end
        n_run++;
        if (rise_t != C_LAT || fall_t != 10 + C_LAT) begin
            n_fail++;
            $display("FAIL short_press_edges: rise %0d fall %0d expected rise %0d fall %0d",
                     rise_t, fall_t, C_LAT, 10 + C_LAT);
        end
        n_run++;
        if (n_hold != 0) begin
            n_fail++;
            $display("FAIL short_press_hold: got %0d expected 0", n_hold);
        end
    endtask

    task automatic test_simultaneous_and_reset();
        int          rise_t   = 0;
        logic [3:0]  rise_val = 4'b0000;
        int          n_bad    = 0;
        logic [15:0] outs;
        apply_reset();
        bus.sw = 4'b1111;
        for (int t = 1; t <= 10; t++) begin
            tick();
            if (bus.rise !== 4'b0000 && rise_t == 0) begin
                rise_t   = t;
                rise_val = bus.rise;
            end
        end
        n_run++;
        if (rise_t != C_LAT || rise_val !== 4'b1111) begin
            n_fail++;
            $display("FAIL simul_rise: tick %0d value %b expected tick %0d value 1111",
                     rise_t, rise_val, C_LAT);
        end
        n_run++;
        if (bus.deb !== 4'b1111) begin
            n_fail++;
            $display("FAIL simul_deb: got %b expected 1111", bus.deb);
        end
        // Two cycles into a free-running window, assert reset between edges.
        tick();
        tick();
        #2;
        rst    = 1'b1;
        bus.sw = 4'b0000;
        #1;
        outs = {bus.deb, bus.rise, bus.fall, bus.hold};
        n_run++;
        if (outs !== 16'h0000) begin
            n_fail++;
            $display("FAIL async_reset: outputs=%h expected 0000", outs);
        end
        repeat (3) tick();
        rst = 1'b0;
        for (int t = 1; t <= 20; t++) begin
            tick();
            if ({bus.deb, bus.rise, bus.fall, bus.hold} !== 16'h0000) n_bad++;
        end
        n_run++;
        if (n_bad != 0) begin
            n_fail++;
            $display("FAIL post_reset_quiet: %0d nonzero cycles expected 0", n_bad);
        end
    endtask

    initial begin
        n_run  = 0;
        n_fail = 0;
        rst    = 1'b1;
        bus.sw = 4'b0000;
        test_reset();
        test_clean_step();
        test_bounce();
        test_glitch();
        test_long_press();
        test_simultaneous_and_reset();
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule : tb_debouncer_multi
`default_nettype wire

// File: doc/debouncer_multi.md
Name: debouncer_multi

Overview:
Multi-channel successor of the single-input switch debouncer: CHANNELS independent asynchronous inputs (buttons, DIP switches, UART-board jumpers). Each channel is synchronised, debounced over a parametrised stable window, and produces a debounced level plus rise, fall and long-press (hold) one-cycle ticks. Sits between board pins and control logic (UART config, menu FSMs).

Parameters:
CHANNELS, 4, number of independent input channels (>=1)
SYS_FREQ, 100_000_000, clk frequency in Hz
TIME_LAPES, 10, stable window length in TIME_BASE units
TIME_BASE, 1000, time unit divisor (1000: ms, 1_000_000: us)
SYNC_STAGES, 2, synchroniser flops per channel (>=2)
RESET_LEVEL, {CHANNELS{1'b0}}, per-channel reset value of the synchroniser and the debounced level
HOLD_PERIODS, 100, stable-high windows after rise before the hold tick; 0 disables hold

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  asynchronous, active-high reset
sw  in  CHANNELS  raw asynchronous inputs
deb  out  CHANNELS  debounced levels
rise  out  CHANNELS  1-cycle tick, deb[i] 0->1
fall  out  CHANNELS  1-cycle tick, deb[i] 1->0
hold  out  CHANNELS  1-cycle tick, long press detected

Behaviour:
- COUNTER = SYS_FREQ/TIME_BASE*TIME_LAPES; CW = $clog2(COUNTER). COUNTER < 2 is an elaboration error.
- Reset (async, any time, including mid-window): sync chain[i] and last[i] = RESET_LEVEL[i], deb[i] = RESET_LEVEL[i], cnt = 0, hold_cnt = 0, rise/fall/hold = 0. No tick is generated on reset release.
- Per channel, each clk edge:
  - Synchroniser: SYNC_STAGES-deep shift of sw[i] -> s[i]; last[i] <= s[i].
  - chg = s[i] ^ last[i].
  - chg = 1: cnt <= 0.
  - Else cnt == COUNTER-1 (terminal): cnt <= 0, deb[i] <= last[i].
  - Else cnt <= cnt + 1.
- Latency: a clean step on sw[i] is visible on deb[i] exactly SYNC_STAGES+COUNTER+1 edges after the first edge that samples the new level.
- A pulse or bounce train with any gap shorter than COUNTER stable cycles restarts the window. A glitch that returns to the old level before the window completes never changes deb.
- A terminal event with last == deb is a no-op for deb. The counter keeps free-running so that the hold window timing is preserved.
- rise/fall: registered on the same edge that updates deb. rise[i] = 1 for exactly the first cycle deb[i] reads 1; fall[i] likewise for 0. Otherwise 0.
- hold (HOLD_PERIODS > 0):
  - hold_cnt width = $clog2(HOLD_PERIODS+1).
  - hold_cnt is cleared on the edge deb[i] is set to 0 or 1 by a change, and while deb[i] = 0.
  - While deb[i] = 1, each terminal event increments hold_cnt, saturating at HOLD_PERIODS.
  - hold[i] pulses one cycle on the edge hold_cnt reaches HOLD_PERIODS, i.e. HOLD_PERIODS*COUNTER cycles after rise[i] if there are no bounces. It fires at most once per press.
  - A fall before that point cancels it.
- hold (HOLD_PERIODS = 0): hold tied to 0 and no hold_cnt logic is generated.
- Channels are fully independent: simultaneous changes on several channels give simultaneous, independent ticks. rise and fall are never both high on one channel.

Decomposition:
- Package debounce_pkg: function counter_value(SYS_FREQ, TIME_BASE, TIME_LAPES) and width helper clog2_min1 (returns >= 1).
- Sub-module debounce_channel: synchroniser, window counter, deb/rise/fall/hold for one channel. It is instantiated CHANNELS times in a generate loop.
- The top level only slices the vectors.

Test Plan:
All tests use SYS_FREQ=1000, TIME_BASE=1000, TIME_LAPES=4 (COUNTER=4), SYNC_STAGES=2, HOLD_PERIODS=3, CHANNELS=4, RESET_LEVEL=4'b0000.
1. Reset: hold rst, then release with sw=4'b0000. -> deb=0, rise/fall/hold=0 for 20 cycles.
2. Clean step on sw[0] 0->1, applied just before edge E. -> deb[0]=1 and rise[0]=1 for one cycle starting 7 edges after E; other channels unchanged.
3. Bounce on sw[1]: 1,0,1,0 with 2-cycle spacing, then stable 1. -> deb[1] rises 7 edges after the final transition; exactly one rise tick; no fall tick.
4. Glitch: sw[2]=1 for 3 cycles, then back to 0. -> deb[2] stays 0 and no ticks.
5. Long press: sw[3]=1 held for 30 cycles. -> rise[3] at cycle R, then hold[3] one cycle at R+12 and no second hold. Release gives fall[3] 7 edges after the release sample. A second press released before R+12 gives no hold.
6. Simultaneous events and mid-window reset:
   - sw=4'b1111 at once -> rise=4'b1111 in the same cycle.
   - Assert rst 2 cycles into a window -> all outputs 0 immediately (asynchronous), with no tick after release.
